// File: rtl/loop_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : loop_pkg
//  Brief    : Shared types and default widths for the loop address generator.
//  Revision : 1.0  initial release
// ============================================================================
package loop_pkg;

    // Default width of loop indices and bounds
    localparam int LOOP_W_DEF  = 16;
    // Default width of addresses, base and strides
    localparam int LOOP_AW_DEF = 16;

    // Sequencer states
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

endpackage : loop_pkg
`default_nettype wire

// File: rtl/loop_idx_cnt.sv
`default_nettype none
// ============================================================================
//  Module   : loop_idx_cnt
//  Brief    : One loop index counter. Counts 0..i_fin inclusive and returns to
//             0 after i_fin; o_wrap marks an increment taken at i_fin, which
//             is the carry into the next-outer counter.
//  Revision : 1.0  initial release
// ============================================================================
module loop_idx_cnt
    import loop_pkg::*;
#(
    parameter int W = LOOP_W_DEF
) (
    input  logic         clk,
    input  logic         rst,       // asynchronous, active low
    input  logic         i_clr,     // load zero
    input  logic         i_inc,     // advance by one
    input  logic [W-1:0] i_fin,     // terminal value, inclusive
    output logic [W-1:0] o_idx,
    output logic         o_at_fin,
    output logic         o_wrap
);

    logic [W-1:0] r_idx;

    assign o_idx    = r_idx;
    assign o_at_fin = (r_idx == i_fin);
    assign o_wrap   = i_inc & o_at_fin;

    // Index register: clearing wins over incrementing; never counts past i_fin
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_idx <= '0;
        end else if (i_clr) begin
            r_idx <= '0;
        end else if (i_inc) begin
            r_idx <= o_at_fin ? '0 : (r_idx + W'(1));
        end
    end

endmodule : loop_idx_cnt
`default_nettype wire

// File: rtl/loop_addr_gen.sv
`default_nettype none
// ============================================================================
//  Module   : loop_addr_gen
//  Brief    : Three-level nested-loop address sequencer. Walks idx0 (inner),
//             idx1, idx2 over inclusive ranges and emits one flat address per
//             beat over valid/ready, using incremental row/plane bases.
//  Options  : LOOP_ADDR_GEN_ABORT_EN adds an 'abort' input that returns the
//             sequencer to idle on the next edge without a done pulse.
//  Revision : 1.0  initial release
// ============================================================================
module loop_addr_gen
    import loop_pkg::*;
#(
    parameter int W  = LOOP_W_DEF,
    parameter int AW = LOOP_AW_DEF
) (
    input  logic          clk,
    input  logic          rst,        // asynchronous, active low
    input  logic          start,
    input  logic [W-1:0]  fin0,
    input  logic [W-1:0]  fin1,
    input  logic [W-1:0]  fin2,
    input  logic [AW-1:0] base,
    input  logic [AW-1:0] stride1,
    input  logic [AW-1:0] stride2,
`ifdef LOOP_ADDR_GEN_ABORT_EN
    input  logic          abort,
`endif
    output logic          busy,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [AW-1:0] out_addr,
    output logic [W-1:0]  out_idx0,
    output logic [W-1:0]  out_idx1,
    output logic [W-1:0]  out_idx2,
    output logic          out_first,
    output logic          out_last,
    output logic          done
);

    state_t        r_state;
    logic          r_busy;
    logic          r_valid;
    logic          r_first;
    logic          r_done;

    logic [W-1:0]  r_fin0;
    logic [W-1:0]  r_fin1;
    logic [W-1:0]  r_fin2;
    logic [AW-1:0] r_stride1;
    logic [AW-1:0] r_stride2;
    logic [AW-1:0] r_addr;
    logic [AW-1:0] r_row_base;
    logic [AW-1:0] r_plane_base;

    logic          w_abort;
    logic          w_start_acc;
    logic          w_accept;
    logic          w_inc0;
    logic [W-1:0]  w_idx0;
    logic [W-1:0]  w_idx1;
    logic [W-1:0]  w_idx2;
    logic          w_at0;
    logic          w_at1;
    logic          w_at2;
    logic          w_wrap0;
    logic          w_wrap1;
    logic          w_wrap2;
    logic          w_step_col;
    logic          w_step_row;
    logic          w_step_plane;
    logic [AW-1:0] w_row_next;
    logic [AW-1:0] w_plane_next;

`ifdef LOOP_ADDR_GEN_ABORT_EN
    // Abort only acts while a walk is in flight; in idle it just masks start
    assign w_abort = abort;
`else
    assign w_abort = 1'b0;
`endif

    assign w_start_acc = (r_state == ST_IDLE) & start & ~w_abort;
    assign w_accept    = r_valid & out_ready;
    // Abort outranks a simultaneous accept, so the beat is not consumed
    assign w_inc0      = w_accept & ~w_abort;

    // The innermost counter moves on every accept; outer counters take the
    // carry. On the final beat all three wrap, and w_wrap2 marks completion.
    loop_idx_cnt #(.W(W)) u_cnt0 (
        .clk      (clk),
        .rst      (rst),
        .i_clr    (w_start_acc),
        .i_inc    (w_inc0),
        .i_fin    (r_fin0),
        .o_idx    (w_idx0),
        .o_at_fin (w_at0),
        .o_wrap   (w_wrap0)
    );

    loop_idx_cnt #(.W(W)) u_cnt1 (
        .clk      (clk),
        .rst      (rst),
        .i_clr    (w_start_acc),
        .i_inc    (w_wrap0),
        .i_fin    (r_fin1),
        .o_idx    (w_idx1),
        .o_at_fin (w_at1),
        .o_wrap   (w_wrap1)
    );

    loop_idx_cnt #(.W(W)) u_cnt2 (
        .clk      (clk),
        .rst      (rst),
        .i_clr    (w_start_acc),
        .i_inc    (w_wrap1),
        .i_fin    (r_fin2),
        .o_idx    (w_idx2),
        .o_at_fin (w_at2),
        .o_wrap   (w_wrap2)
    );

    // Exactly one of these fires per non-final accept
    assign w_step_col   = w_inc0 & ~w_at0;
    assign w_step_row   = w_wrap0 & ~w_at1;
    assign w_step_plane = w_wrap1 & ~w_at2;

    assign w_row_next   = r_row_base + r_stride1;
    assign w_plane_next = r_plane_base + r_stride2;

    // Control FSM with registered handshake/status outputs
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= ST_IDLE;
            r_busy  <= 1'b0;
            r_valid <= 1'b0;
            r_first <= 1'b0;
            r_done  <= 1'b0;
        end else if (w_abort && (r_state != ST_IDLE)) begin
            r_state <= ST_IDLE;
            r_busy  <= 1'b0;
            r_valid <= 1'b0;
            r_first <= 1'b0;
            r_done  <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    r_done <= 1'b0;
                    if (w_start_acc) begin
                        r_state <= ST_RUN;
                        r_busy  <= 1'b1;
                        r_valid <= 1'b1;
                        r_first <= 1'b1;
                    end
                end
                ST_RUN: begin
                    if (w_accept) begin
                        r_first <= 1'b0;
                    end
                    if (w_wrap2) begin
                        r_state <= ST_DONE;
                        r_busy  <= 1'b0;
                        r_valid <= 1'b0;
                        r_done  <= 1'b1;
                    end
                end
                ST_DONE: begin
                    r_state <= ST_IDLE;
                    r_done  <= 1'b0;
                end
                default: begin
                    r_state <= ST_IDLE;
                    r_busy  <= 1'b0;
                    r_valid <= 1'b0;
                    r_first <= 1'b0;
                    r_done  <= 1'b0;
                end
            endcase
        end
    end

    // Config shadow and address/base registers; sums wrap modulo 2^AW
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_fin0       <= '0;
            r_fin1       <= '0;
            r_fin2       <= '0;
            r_stride1    <= '0;
            r_stride2    <= '0;
            r_addr       <= '0;
            r_row_base   <= '0;
            r_plane_base <= '0;
        end else if (w_start_acc) begin
            r_fin0       <= fin0;
            r_fin1       <= fin1;
            r_fin2       <= fin2;
            r_stride1    <= stride1;
            r_stride2    <= stride2;
            r_addr       <= base;
            r_row_base   <= base;
            r_plane_base <= base;
        end else if (w_step_col) begin
            r_addr       <= r_addr + AW'(1);
        end else if (w_step_row) begin
            r_row_base   <= w_row_next;
            r_addr       <= w_row_next;
        end else if (w_step_plane) begin
            r_plane_base <= w_plane_next;
            r_row_base   <= w_plane_next;
            r_addr       <= w_plane_next;
        end
    end

    assign busy      = r_busy;
    assign out_valid = r_valid;
    assign out_addr  = r_addr;
    assign out_idx0  = w_idx0;
    assign out_idx1  = w_idx1;
    assign out_idx2  = w_idx2;
    assign out_first = r_first;
    assign out_last  = w_at0 & w_at1 & w_at2 & r_valid;
    assign done      = r_done;

endmodule : loop_addr_gen
`default_nettype wire
